// File: rtl/sram_pkg.sv
// Shared SRAM pin-interface definitions: bus widths, responder FSM states, byte-lane decode.
// Pure declarations: no latency, no backpressure.
package sram_pkg;

  localparam int SRAM_DATA_W = 64;
  localparam int SRAM_ADDR_W = 17;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    READ_DRIVE
  } sram_state_t;

  // Half-word lane enables {upper, lower} from the active-low UB_N/LB_N pins.
  function automatic logic [1:0] lane_mask(input logic ub_n, input logic lb_n);
    return {~ub_n, ~lb_n};
  endfunction

endpackage

// File: rtl/sram_lane_array.sv
// DEPTH x DATA_W storage split into upper/lower halves, each with its own write enable.
// Write commits on the clock edge, read is combinational; no backpressure.
module sram_lane_array #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic [1:0]        we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int HALF = DATA_W / 2;

  logic [HALF-1:0] mem_hi [DEPTH];
  logic [HALF-1:0] mem_lo [DEPTH];

  always_ff @(posedge clk) begin
    if (we[1]) mem_hi[waddr] <= wdata[DATA_W-1:HALF];
    if (we[0]) mem_lo[waddr] <= wdata[HALF-1:0];
  end

  assign rdata = {mem_hi[raddr], mem_lo[raddr]};

endmodule

// File: rtl/sram_device_model.sv
// Cycle-based responder for the external SRAM pins: stores writes, returns reads on SRAM_DQ.
// Read data drives READ_LAT+1 edges after a stable read address is first sampled; no backpressure.
module sram_device_model
  import sram_pkg::*;
#(
  parameter int DATA_W   = SRAM_DATA_W,
  parameter int ADDR_W   = SRAM_ADDR_W,
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  output logic              busy
);

  localparam int          HALF  = DATA_W / 2;
  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [2:0]  LAT   = 3'(READ_LAT);

  sram_state_t       state, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        lane_en;
  logic [1:0]        mem_we;
  logic              wr, rd, drive;

  assign wr      = !SRAM_CE_N && !SRAM_WE_N;
  assign rd      = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
  assign lane_en = lane_mask(SRAM_UB_N, SRAM_LB_N);
  // Writes are gated by reset so a write cycle overlapping reset leaves memory untouched.
  assign mem_we  = (wr && rst) ? lane_en : 2'b00;

  sram_lane_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(SRAM_ADDR[IDX_W-1:0]),
    .wdata(SRAM_DQ),
    .raddr(addr_q[IDX_W-1:0]),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt_q  <= '0;
      addr_q <= '0;
      rd_q   <= '0;
    end else begin
      state  <= state_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      rd_q   <= rd_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    case (state)
      IDLE: begin
        if (rd) begin
          state_d = READ_WAIT;
          addr_d  = SRAM_ADDR;
          cnt_d   = 3'd1;
        end
      end
      READ_WAIT: begin
        if (!rd) begin
          state_d = IDLE;
        end else if (SRAM_ADDR != addr_q) begin
          addr_d = SRAM_ADDR;
          cnt_d  = 3'd1;
        end else if (cnt_q == LAT) begin
          rd_d    = mem_rdata;
          state_d = READ_DRIVE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      READ_DRIVE: begin
        if (!rd) begin
          state_d = IDLE;
        end else if (SRAM_ADDR != addr_q) begin
          state_d = READ_WAIT;
          addr_d  = SRAM_ADDR;
          cnt_d   = 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rd is combinational, so any WE_N/OE_N/CE_N change releases the bus in the same cycle.
  assign drive = (state == READ_DRIVE) && rd;
  assign SRAM_DQ[DATA_W-1:HALF] = (drive && lane_en[1]) ? rd_q[DATA_W-1:HALF] : 'z;
  assign SRAM_DQ[HALF-1:0]      = (drive && lane_en[0]) ? rd_q[HALF-1:0]      : 'z;

  assign busy = (state == READ_WAIT);

endmodule

// File: tb/tb_sram_device_model.sv
// Bench for sram_device_model: vector table of writes/reads plus hand-built corner sequences.
// The data bus is pulled up, so a released (z) lane reads back as all ones.
module tb_sram_device_model;
  import sram_pkg::*;

  localparam int DW    = 64;
  localparam int AW    = 17;
  localparam int DEPTH = 1024;
  localparam int RL    = 2;
  localparam logic [DW-1:0] ZV = '1;

  logic          clk = 1'b0;
  logic          rst;
  tri1  [DW-1:0] dq;
  logic [DW-1:0] dq_drv;
  logic          dq_oe;
  logic [AW-1:0] addr;
  logic          ub_n, lb_n, we_n, ce_n, oe_n;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] sb[$];

  assign dq = dq_oe ? dq_drv : 'z;

  always #5 clk = ~clk;

  sram_device_model #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LAT(RL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .SRAM_DQ  (dq),
    .SRAM_ADDR(addr),
    .SRAM_UB_N(ub_n),
    .SRAM_LB_N(lb_n),
    .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n),
    .SRAM_OE_N(oe_n),
    .busy     (busy)
  );

  typedef struct {
    bit            wr;
    logic [AW-1:0] a;
    logic          ub;
    logic          lb;
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
    int            reps;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bus cycle: drive at the falling edge, settle, then the caller samples.
  task automatic bus(input logic c, input logic o, input logic w, input logic u, input logic l,
                     input logic [AW-1:0] a, input logic doe, input logic [DW-1:0] d);
    @(negedge clk);
    ce_n = c; oe_n = o; we_n = w; ub_n = u; lb_n = l; addr = a; dq_oe = doe; dq_drv = d;
    #1;
  endtask

  task automatic nop();
    bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, 1'b0, '0);
  endtask

  task automatic rd_cyc(input logic [AW-1:0] a, input logic u, input logic l);
    bus(1'b0, 1'b0, 1'b1, u, l, a, 1'b0, '0);
  endtask

  task automatic wr_cyc(input logic [AW-1:0] a, input logic u, input logic l, input logic [DW-1:0] d);
    bus(1'b0, 1'b1, 1'b0, u, l, a, 1'b1, d);
  endtask

  task automatic wr_txn(input logic [AW-1:0] a, input logic u, input logic l,
                        input logic [DW-1:0] d, input int reps);
    for (int r = 0; r < reps; r++) wr_cyc(a, u, l, d);
    nop();
  endtask

  // Hold a read until data appears: z for RL+1 sampled edges, then the expected word.
  task automatic to_drive(input logic [AW-1:0] a, input logic u, input logic l,
                          input logic [DW-1:0] exp, input string nm);
    logic [DW-1:0] e;
    sb.push_back(exp);
    for (int c = 0; c <= RL; c++) begin
      rd_cyc(a, u, l);
      chk($sformatf("%s wait%0d dq", nm, c), dq, ZV);
      if (c > 0) chk($sformatf("%s wait%0d busy", nm, c), 64'(busy), 64'd1);
    end
    rd_cyc(a, u, l);
    e = sb.pop_front();
    chk($sformatf("%s data", nm), dq, e);
    chk($sformatf("%s drive busy", nm), 64'(busy), 64'd0);
  endtask

  task automatic rd_txn(input logic [AW-1:0] a, input logic u, input logic l,
                        input logic [DW-1:0] exp, input string nm);
    to_drive(a, u, l, exp, nm);
    nop();
    chk({nm, " release"}, dq, ZV);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tbl.push_back('{1'b1, 17'h00005, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0, 3});
    tbl.push_back('{1'b0, 17'h00005, 1'b0, 1'b0, 64'h0, 64'h0123_4567_89AB_CDEF, 1});
    tbl.push_back('{1'b1, 17'h00007, 1'b0, 1'b0, 64'h1111_1111_2222_2222, 64'h0, 1});
    tbl.push_back('{1'b1, 17'h00007, 1'b0, 1'b1, 64'hAAAA_AAAA_BBBB_BBBB, 64'h0, 1});
    tbl.push_back('{1'b0, 17'h00007, 1'b0, 1'b0, 64'h0, 64'hAAAA_AAAA_2222_2222, 1});
    tbl.push_back('{1'b0, 17'h00007, 1'b1, 1'b0, 64'h0, 64'hFFFF_FFFF_2222_2222, 1});
    tbl.push_back('{1'b0, 17'h00007, 1'b0, 1'b1, 64'h0, 64'hAAAA_AAAA_FFFF_FFFF, 1});
    tbl.push_back('{1'b1, 17'h00400, 1'b0, 1'b0, 64'h5A5A_0F0F_C3C3_9696, 64'h0, 1});
    tbl.push_back('{1'b0, 17'h00000, 1'b0, 1'b0, 64'h0, 64'h5A5A_0F0F_C3C3_9696, 1});
    tbl.push_back('{1'b1, 17'h00408, 1'b0, 1'b0, 64'h0000_0000_CAFE_F00D, 64'h0, 1});
    tbl.push_back('{1'b0, 17'h00008, 1'b0, 1'b0, 64'h0, 64'h0000_0000_CAFE_F00D, 1});
    tbl.push_back('{1'b0, 17'h1FC08, 1'b0, 1'b0, 64'h0, 64'h0000_0000_CAFE_F00D, 1});
    tbl.push_back('{1'b1, 17'h00009, 1'b0, 1'b0, 64'h3333_3333_3333_3333, 64'h0, 1});
    tbl.push_back('{1'b1, 17'h00009, 1'b0, 1'b0, 64'h4444_4444_5555_5555, 64'h0, 2});
    tbl.push_back('{1'b1, 17'h00009, 1'b1, 1'b1, 64'h0, 64'h0, 1});
    tbl.push_back('{1'b0, 17'h00009, 1'b0, 1'b0, 64'h0, 64'h4444_4444_5555_5555, 1});

    rst = 1'b0; dq_oe = 1'b0; dq_drv = '0; addr = '0;
    ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
    repeat (3) nop();
    chk("reset dq", dq, ZV);
    chk("reset busy", 64'(busy), 64'd0);
    @(negedge clk) rst = 1'b1;
    nop();

    foreach (tbl[i]) begin
      if (tbl[i].wr) wr_txn(tbl[i].a, tbl[i].ub, tbl[i].lb, tbl[i].d, tbl[i].reps);
      else           rd_txn(tbl[i].a, tbl[i].ub, tbl[i].lb, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Reset in the middle of a read at addr 5; a write attempted during reset must not land.
    rd_cyc(17'h5, 1'b0, 1'b0);
    rd_cyc(17'h5, 1'b0, 1'b0);
    chk("rst midread busy before", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("rst midread dq", dq, ZV);
    chk("rst midread busy", 64'(busy), 64'd0);
    wr_cyc(17'h5, 1'b0, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF);
    nop();
    @(negedge clk) rst = 1'b1;
    rd_txn(17'h5, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, "post reset");

    // Address change during the wait restarts the count; mem[3] is never driven.
    wr_txn(17'h3, 1'b0, 1'b0, 64'h1357_9BDF_2468_ACE0, 1);
    wr_txn(17'h4, 1'b0, 1'b0, 64'h0F1E_2D3C_4B5A_6978, 1);
    rd_cyc(17'h3, 1'b0, 1'b0);
    chk("addr chg first dq", dq, ZV);
    rd_txn(17'h4, 1'b0, 1'b0, 64'h0F1E_2D3C_4B5A_6978, "addr chg");

    // Write during READ_DRIVE: bus released in the same cycle, write commits.
    to_drive(17'h3, 1'b0, 1'b0, 64'h1357_9BDF_2468_ACE0, "pre abort");
    wr_cyc(17'h3, 1'b0, 1'b0, 64'h7766_5544_3322_1100);
    chk("abort drive dq", dq, 64'h7766_5544_3322_1100);
    nop();
    chk("abort drive busy", 64'(busy), 64'd0);
    rd_txn(17'h3, 1'b0, 1'b0, 64'h7766_5544_3322_1100, "after abort drive");

    // Write during READ_WAIT aborts the read and still commits.
    rd_cyc(17'h4, 1'b0, 1'b0);
    rd_cyc(17'h4, 1'b0, 1'b0);
    wr_cyc(17'h4, 1'b0, 1'b0, 64'h0BAD_F00D_1234_5678);
    nop();
    chk("abort wait busy", 64'(busy), 64'd0);
    rd_txn(17'h4, 1'b0, 1'b0, 64'h0BAD_F00D_1234_5678, "after abort wait");

    // CE_N high overrides a read in progress: z at once, FSM back to IDLE.
    to_drive(17'h4, 1'b0, 1'b0, 64'h0BAD_F00D_1234_5678, "pre ce");
    bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 17'h4, 1'b0, '0);
    chk("ce override dq", dq, ZV);
    rd_cyc(17'h4, 1'b0, 1'b0);
    chk("ce override restart dq", dq, ZV);
    nop();

    // OE_N high during READ_DRIVE also releases the bus.
    to_drive(17'h7, 1'b0, 1'b0, 64'hAAAA_AAAA_2222_2222, "pre oe");
    bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 17'h7, 1'b0, '0);
    chk("oe release dq", dq, ZV);
    nop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
